// File: rtl/muldiv_sequencer.sv
// Iterative multiply/divide unit with HI/LO registers and its own sequencer.
// Shift-add multiply or restoring divide, one bit per clock, 33 cycles per operation.
module muldiv_sequencer #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              issue_valid,
  input  logic [5:0]        OpCode,
  input  logic [5:0]        Funct,
  input  logic [DATA_W-1:0] rs_data,
  input  logic [DATA_W-1:0] rt_data,
  output logic              stall,
  output logic              busy,
  output logic [DATA_W-1:0] mf_data,
  output logic [DATA_W-1:0] hi_out,
  output logic [DATA_W-1:0] lo_out
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_FIN  = 2'd3
  } state_t;

  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1a;
  localparam logic [5:0] F_DIVU  = 6'h1b;

  localparam logic [DATA_W-1:0]   ZERO_W   = {DATA_W{1'b0}};
  localparam logic [DATA_W-1:0]   ONES_W   = {DATA_W{1'b1}};
  localparam logic [2*DATA_W-1:0] ZERO_2W  = {(2*DATA_W){1'b0}};
  localparam logic [CNT_W-1:0]    CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]    CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]    CNT_LAST = {CNT_W{1'b1}};

  // Magnitude of an operand; signed ops take |v|, unsigned ops pass v through.
  function automatic logic [DATA_W-1:0] f_mag(input logic [DATA_W-1:0] v, input logic sgn);
    f_mag = (sgn && v[DATA_W-1]) ? (ZERO_W - v) : v;
  endfunction

  function automatic logic [DATA_W-1:0] f_cond_neg(input logic [DATA_W-1:0] v, input logic neg);
    f_cond_neg = neg ? (ZERO_W - v) : v;
  endfunction

  state_t                r_state;
  state_t                w_next_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [DATA_W-1:0]     r_hi;
  logic [DATA_W-1:0]     r_lo;
  logic [2*DATA_W-1:0]   r_work;
  logic [DATA_W-1:0]     r_b;
  logic [DATA_W-1:0]     r_rs_raw;
  logic                  r_neg_q;
  logic                  r_neg_r;
  logic                  r_div0;
  logic                  r_is_div;

  logic                  w_dec;
  logic                  w_is_mul;
  logic                  w_is_div;
  logic                  w_signed;
  logic                  w_is_mfhi;
  logic                  w_is_mflo;
  logic                  w_is_mthi;
  logic                  w_is_mtlo;
  logic                  w_hilo_op;
  logic                  w_start;
  logic                  w_wr_mthi;
  logic                  w_wr_mtlo;

  logic [DATA_W:0]       w_mul_sum;
  logic [2*DATA_W-1:0]   w_mul_step;
  logic [DATA_W:0]       w_div_shift;
  logic [DATA_W:0]       w_div_diff;
  logic [2*DATA_W-1:0]   w_div_step;
  logic [2*DATA_W-1:0]   w_prod;
  logic [DATA_W-1:0]     w_res_hi;
  logic [DATA_W-1:0]     w_res_lo;

  assign w_dec     = issue_valid && (OpCode == 6'h00);
  assign w_is_mul  = w_dec && ((Funct == F_MULT) || (Funct == F_MULTU));
  assign w_is_div  = w_dec && ((Funct == F_DIV)  || (Funct == F_DIVU));
  assign w_signed  = (Funct == F_MULT) || (Funct == F_DIV);
  assign w_is_mfhi = w_dec && (Funct == F_MFHI);
  assign w_is_mflo = w_dec && (Funct == F_MFLO);
  assign w_is_mthi = w_dec && (Funct == F_MTHI);
  assign w_is_mtlo = w_dec && (Funct == F_MTLO);
  assign w_hilo_op = w_is_mul || w_is_div || w_is_mfhi || w_is_mflo || w_is_mthi || w_is_mtlo;

  assign hi_out = r_hi;
  assign lo_out = r_lo;

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_is_mul) begin
          w_next_state = S_MUL;
        end else if (w_is_div) begin
          w_next_state = S_DIV;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_MUL, S_DIV: begin
        if (r_cnt == CNT_LAST) begin
          w_next_state = S_FIN;
        end else begin
          w_next_state = r_state;
        end
      end
      S_FIN:   w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // FSM outputs: hazard stall, busy, move-from read port and IDLE-only strobes
  always_comb begin
    busy      = (r_state != S_IDLE);
    stall     = 1'b0;
    mf_data   = ZERO_W;
    w_start   = 1'b0;
    w_wr_mthi = 1'b0;
    w_wr_mtlo = 1'b0;
    if (reset) begin
      stall   = 1'b0;
      mf_data = ZERO_W;
    end else begin
      stall     = w_hilo_op && (r_state != S_IDLE);
      w_start   = (w_is_mul || w_is_div) && (r_state == S_IDLE);
      w_wr_mthi = w_is_mthi && (r_state == S_IDLE);
      w_wr_mtlo = w_is_mtlo && (r_state == S_IDLE);
      if (w_is_mfhi) begin
        mf_data = r_hi;
      end else if (w_is_mflo) begin
        mf_data = r_lo;
      end else begin
        mf_data = ZERO_W;
      end
    end
  end

  // One iteration step of each algorithm plus final sign correction
  always_comb begin
    w_mul_sum   = {1'b0, r_work[2*DATA_W-1:DATA_W]} + (r_work[0] ? {1'b0, r_b} : {(DATA_W+1){1'b0}});
    w_mul_step  = {w_mul_sum, r_work[DATA_W-1:1]};
    w_div_shift = r_work[2*DATA_W-1:DATA_W-1];
    w_div_diff  = w_div_shift - {1'b0, r_b};
    w_div_step  = ZERO_2W;
    if (!w_div_diff[DATA_W]) begin
      w_div_step = {w_div_diff[DATA_W-1:0], r_work[DATA_W-2:0], 1'b1};
    end else begin
      w_div_step = {w_div_shift[DATA_W-1:0], r_work[DATA_W-2:0], 1'b0};
    end
    w_prod   = r_neg_q ? (ZERO_2W - r_work) : r_work;
    w_res_hi = ZERO_W;
    w_res_lo = ZERO_W;
    if (r_div0) begin
      w_res_hi = r_rs_raw;
      w_res_lo = ONES_W;
    end else if (r_is_div) begin
      w_res_hi = f_cond_neg(r_work[2*DATA_W-1:DATA_W], r_neg_r);
      w_res_lo = f_cond_neg(r_work[DATA_W-1:0], r_neg_q);
    end else begin
      w_res_hi = w_prod[2*DATA_W-1:DATA_W];
      w_res_lo = w_prod[DATA_W-1:0];
    end
  end

  // Datapath: operand capture, iteration, HI/LO writes
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt    <= CNT_ZERO;
      r_hi     <= ZERO_W;
      r_lo     <= ZERO_W;
      r_work   <= ZERO_2W;
      r_b      <= ZERO_W;
      r_rs_raw <= ZERO_W;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_div0   <= 1'b0;
      r_is_div <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_work   <= {ZERO_W, f_mag(rs_data, w_signed)};
            r_b      <= f_mag(rt_data, w_signed);
            r_rs_raw <= rs_data;
            r_neg_q  <= w_signed && (rs_data[DATA_W-1] ^ rt_data[DATA_W-1]);
            r_neg_r  <= w_signed && rs_data[DATA_W-1];
            r_div0   <= w_is_div && (rt_data == ZERO_W);
            r_is_div <= w_is_div;
            r_cnt    <= CNT_ZERO;
          end else if (w_wr_mthi) begin
            r_hi <= rs_data;
          end else if (w_wr_mtlo) begin
            r_lo <= rs_data;
          end
        end
        S_MUL: begin
          r_work <= w_mul_step;
          r_cnt  <= r_cnt + CNT_ONE;
        end
        S_DIV: begin
          r_work <= w_div_step;
          r_cnt  <= r_cnt + CNT_ONE;
        end
        S_FIN: begin
          r_hi <= w_res_hi;
          r_lo <= w_res_lo;
        end
        default: r_cnt <= CNT_ZERO;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: stimulus pushes expected HI/LO,
// a monitor pops and compares each time an operation completes (busy falls).
module tb_muldiv_sequencer;

  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1a;
  localparam logic [5:0] F_DIVU  = 6'h1b;
  localparam logic [5:0] F_ADDU  = 6'h21;

  logic        clk;
  logic        reset;
  logic        issue_valid;
  logic [5:0]  OpCode;
  logic [5:0]  Funct;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        stall;
  logic        busy;
  logic [31:0] mf_data;
  logic [31:0] hi_out;
  logic [31:0] lo_out;

  int n_tests = 0;
  int n_fail  = 0;
  logic [63:0] exp_q[$];

  muldiv_sequencer #(.DATA_W(32), .CNT_W(5)) dut (
    .clk(clk), .reset(reset), .issue_valid(issue_valid), .OpCode(OpCode),
    .Funct(Funct), .rs_data(rs_data), .rt_data(rt_data), .stall(stall),
    .busy(busy), .mf_data(mf_data), .hi_out(hi_out), .lo_out(lo_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one instruction for a single cycle; returns 1 time unit after its edge.
  task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    issue_valid = 1'b1;
    OpCode      = 6'h00;
    Funct       = f;
    rs_data     = a;
    rt_data     = b;
    @(posedge clk); #1;
    issue_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < 100);
    if (busy) begin
      n_tests++;
      n_fail++;
      $display("FAIL wait_idle: busy still %0b after %0d cycles, required 0", busy, n);
    end
    @(posedge clk); #1;
  endtask

  // Monitor: an operation completes when busy falls without a reset at the edge.
  initial begin : monitor
    logic prev_busy;
    logic rst_at_edge;
    logic [63:0] e;
    prev_busy = 1'b0;
    forever begin
      @(posedge clk);
      rst_at_edge = reset;
      @(negedge clk);
      if (prev_busy && !busy && !rst_at_edge) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL sb_unexpected: result hi=%h lo=%h, required no completion", hi_out, lo_out);
        end else begin
          e = exp_q.pop_front();
          check("sb_hi", hi_out, e[63:32]);
          check("sb_lo", lo_out, e[31:0]);
        end
      end
      prev_busy = busy;
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: time limit reached, required completion");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int cyc;
    reset = 1'b1; issue_valid = 1'b0; OpCode = 6'h00; Funct = 6'h00;
    rs_data = 32'h0; rt_data = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    issue_valid = 1'b1; Funct = F_MFLO;
    @(negedge clk);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_stall", {31'h0, stall}, 32'h0);
    check("rst_mf", mf_data, 32'h0);
    check("rst_hi", hi_out, 32'h0);
    check("rst_lo", lo_out, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0; issue_valid = 1'b0;

    // multu max*max, busy window length
    exp_q.push_back({32'hFFFFFFFE, 32'h00000001});
    issue(F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    cyc = 0;
    repeat (40) begin
      @(negedge clk);
      if (busy) cyc++;
    end
    check("busy_cycles", cyc, 32'd33);
    @(posedge clk); #1;

    exp_q.push_back({32'hFFFFFFFF, 32'hFFFFFFF1});
    issue(F_MULT, 32'hFFFFFFFD, 32'd5);
    wait_idle();
    exp_q.push_back({32'hFFFFFFFF, 32'hFFFFFFFD});
    issue(F_DIV, 32'hFFFFFFF9, 32'd2);
    wait_idle();

    // mult 6*7 then mflo held in EX; one addu slipped in mid-operation
    exp_q.push_back({32'h0, 32'd42});
    issue(F_MULT, 32'd6, 32'd7);
    for (int k = 1; k <= 34; k++) begin
      issue_valid = 1'b1; OpCode = 6'h00;
      Funct = (k == 11) ? F_ADDU : F_MFLO;
      @(negedge clk);
      if (k == 34) begin
        check("stall_released", {31'h0, stall}, 32'h0);
        check("mflo_after_op", mf_data, 32'd42);
      end else if (k == 11) begin
        check("addu_no_stall", {31'h0, stall}, 32'h0);
      end else if (k == 1 || k == 33) begin
        check("mflo_stall", {31'h0, stall}, 32'h1);
      end else if (!stall) begin
        check("mflo_stall_mid", {31'h0, stall}, 32'h1);
      end
      @(posedge clk); #1;
    end
    issue_valid = 1'b0;

    exp_q.push_back({32'd100, 32'hFFFFFFFF});
    issue(F_DIVU, 32'd100, 32'd0);
    wait_idle();
    exp_q.push_back({32'hFFFFFFF9, 32'hFFFFFFFF});
    issue(F_DIV, 32'hFFFFFFF9, 32'd0);
    wait_idle();
    exp_q.push_back({32'h0, 32'h80000000});
    issue(F_DIV, 32'h80000000, 32'hFFFFFFFF);
    wait_idle();

    // back-to-back start: second held through FIN, accepted first IDLE cycle
    exp_q.push_back({32'h0, 32'd6});
    exp_q.push_back({32'h0, 32'd20});
    issue(F_MULT, 32'd2, 32'd3);
    issue_valid = 1'b1; Funct = F_MULTU; rs_data = 32'd4; rt_data = 32'd5;
    cyc = 0;
    @(negedge clk);
    while (stall && cyc < 60) begin
      cyc++;
      @(negedge clk);
    end
    check("restart_stall_cycles", cyc, 32'd33);
    @(posedge clk); #1;
    issue_valid = 1'b0;
    wait_idle();

    // moves in IDLE
    issue_valid = 1'b1; Funct = F_MTHI; rs_data = 32'h12345678;
    @(negedge clk);
    check("mthi_no_stall", {31'h0, stall}, 32'h0);
    @(posedge clk); #1;
    issue_valid = 1'b0;
    @(negedge clk);
    check("mthi_hi", hi_out, 32'h12345678);
    @(posedge clk); #1;
    issue(F_MTLO, 32'hCAFEF00D, 32'h0);
    issue_valid = 1'b1; Funct = F_MFHI;
    @(negedge clk);
    check("mtlo_lo", lo_out, 32'hCAFEF00D);
    check("mfhi_read", mf_data, 32'h12345678);
    @(posedge clk); #1;
    issue_valid = 1'b0;

    // reset mid-multiply (cnt==10) together with a presented start
    issue(F_MULT, 32'd2, 32'd3);
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b1;
    issue_valid = 1'b1; Funct = F_MULT; rs_data = 32'd9; rt_data = 32'd9;
    @(posedge clk); #1;
    reset = 1'b0; issue_valid = 1'b0;
    @(negedge clk);
    check("abort_busy", {31'h0, busy}, 32'h0);
    check("abort_hi", hi_out, 32'h0);
    check("abort_lo", lo_out, 32'h0);
    repeat (40) @(negedge clk);
    check("no_late_busy", {31'h0, busy}, 32'h0);
    check("no_late_hi", hi_out, 32'h0);
    check("no_late_lo", lo_out, 32'h0);

    check("sb_drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
